// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, carry, zero, neg, ovf
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, carry, zero, neg, ovf
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result/flags and shift-add multiply
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_ADDC = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic               accept;
  logic               cin;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] acc_step;

  logic               load;
  logic [WIDTH-1:0]   ld_r;
  logic               ld_c;
  logic               ld_v;
  logic               ld_upd;

  // A new beat is only taken when idle and the output slot is free or draining this cycle.
  assign bus.in_ready = !rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign cin      = (bus.opcode == OP_ADDC) ? c_q : 1'b0;
  assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, cin};
  assign diff_ext = {1'b0, bus.A} - {1'b0, bus.B};
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;

  // Next-state: FSM transitions, multiply iteration and output-register load.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    load        = 1'b0;
    ld_r        = '0;
    ld_c        = 1'b0;
    ld_v        = 1'b0;
    ld_upd      = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.opcode)
            OP_ADD, OP_ADDC: begin
              load   = 1'b1;
              ld_r   = sum_ext[WIDTH-1:0];
              ld_c   = sum_ext[WIDTH];
              ld_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_ext[WIDTH-1] != bus.A[WIDTH-1]);
              ld_upd = 1'b1;
            end
            OP_SUB: begin
              load   = 1'b1;
              ld_r   = diff_ext[WIDTH-1:0];
              ld_c   = diff_ext[WIDTH];
              ld_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_ext[WIDTH-1] != bus.A[WIDTH-1]);
              ld_upd = 1'b1;
            end
            OP_AND: begin
              load = 1'b1;
              ld_r = bus.A & bus.B;
            end
            OP_OR: begin
              load = 1'b1;
              ld_r = bus.A | bus.B;
            end
            OP_XOR: begin
              load = 1'b1;
              ld_r = bus.A ^ bus.B;
            end
            OP_NOT: begin
              load = 1'b1;
              ld_r = ~bus.A;
            end
            OP_MUL: begin
              state_d  = S_MUL;
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, bus.A};
              mplier_d = bus.B;
              cnt_d    = '0;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          load    = 1'b1;
          ld_r    = acc_step[WIDTH-1:0];
          ld_c    = |acc_step[2*WIDTH-1:WIDTH];
          ld_upd  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      result_d    = ld_r;
      carry_d     = ld_c;
      zero_d      = (ld_r == '0);
      neg_d       = ld_r[WIDTH-1];
      ovf_d       = ld_v;
      if (ld_upd) begin
        c_d = ld_c;
      end
    end
  end

  // State register; reset also aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
    end
  end

endmodule
